mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Iterative RV32M multiply/divide unit; the multi-cycle execution counterpart of the single-cycle integer ALU in the execute stage.
- Accepts one operation per request handshake, computes it with a radix-2 shift-add or shift-subtract datapath, and holds the result until the pipeline consumes it.
- Execute stage stalls on req_ready/resp_valid.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
flush  input  1  pipeline kill; abandons any in-flight operation
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_lhs  input  32  rs1 operand
req_rhs  input  32  rs2 operand
resp_valid  output  1  resp_result valid
resp_ready  input  1  consumer takes result
resp_result  output  32  result
busy  output  1  state != IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_result=0, busy=0, counter=0.
- rst wins over every other input in the same cycle, including when an operation is in CALC or DONE.
- States and transitions:
  - IDLE: req_ready=1. A request is accepted in cycle T when req_valid && req_ready && !flush. At accept, latch op, latch operand signs, and take absolute values (signed ops only). Next state is CALC, or DONE when the fast path applies.
  - CALC: req_ready=0. Counter runs 0..31; one iteration per cycle. On counter==31 go to DONE.
  - DONE: resp_valid=1 and resp_result stable. If resp_ready: go to IDLE, resp_valid drops in the next cycle. req_ready=0 in DONE; there is no back-to-back accept in the same cycle as the response.
- Normal latency: accept in cycle T; resp_valid=1 from cycle T+33 until resp_ready is sampled high.
- flush in CALC or DONE: return to IDLE next cycle, resp_valid=0, no result delivered. flush in IDLE: blocks acceptance that cycle.
- Multiply: 64-bit product from unsigned magnitudes; two's-complement negate when signs differ.
  - MULHSU: lhs signed, rhs unsigned.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = lhs_sign ^ rhs_sign.
  - Remainder sign = lhs_sign.
- Special cases (RISC-V spec):
  - Divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = lhs.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Input operands may change after accept; the latched copies are used.
- resp_result holds its value while resp_valid=1 and resp_ready=0.

Optional Feature:
- Macro MDU_FAST_PATH_EN.
- Defined: divide by zero, signed overflow, and any multiply with an operand equal to 0 bypass CALC. Accept at T → DONE with resp_valid=1 in T+1.
- Undefined: these cases take the normal 33-cycle path and produce identical results. No fast-path logic is synthesized.

Test Plan:
- MUL 7 × −3 (0x00000007, 0xFFFFFFFD) → resp_result 0xFFFFFFEB at T+33; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 0x80000000/3 → 0x2AAAAAAA; REMU same → 0x00000002.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - With MDU_FAST_PATH_EN: resp_valid at T+1.
  - Without: resp_valid at T+33.
- resp_ready held low 5 cycles after resp_valid → resp_valid and resp_result stay stable, req_ready=0. Then resp_ready=1 → IDLE next cycle, req_ready=1.
- flush at T+10 of a DIV → IDLE at T+11, resp_valid never asserted. A new MULH 0x40000000×4 (product 0x1_00000000) is then accepted and returns 0x00000001.
- rst asserted while in CALC and while in DONE → all outputs at reset values next cycle; a request held on req_valid during rst is not accepted.

Source files
------------

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative RV32M multiply/divide unit (radix-2 shift-add / restoring shift-subtract)
//
// Purpose:
//   Takes one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request per handshake,
//   iterates one bit per cycle for 32 cycles on operand magnitudes, fixes up
//   the sign at the end and holds the result until the consumer takes it.
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_i          synchronous active-high reset, dominates every other input
//   flush_i        abandons an in-flight operation, blocks accept in IDLE
//   req_valid_i    request present
//   req_ready_o    unit idle and able to accept
//   req_op_i       funct3 (0 MUL .. 7 REMU)
//   req_lhs_i      rs1 operand
//   req_rhs_i      rs2 operand
//   resp_valid_o   resp_result_o valid
//   resp_ready_i   consumer takes the result
//   resp_result_o  result
//   busy_o         unit not in IDLE
//
// Configuration:
//   MDU_FAST_PATH_EN - when defined, divide-by-zero, signed overflow and
//   multiplies with a zero operand skip the iteration and respond one cycle
//   after accept. When undefined those cases run the full iteration.
module mdu_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_lhs_i,
    input  logic [XLEN-1:0] req_rhs_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_result_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q;
    logic              sign_l_q;
    logic              sign_r_q;
    logic              div_zero_q;
    logic [XLEN-1:0]   hi_q;      // product high half / partial remainder
    logic [XLEN-1:0]   lo_q;      // multiplier shifting out / dividend shifting into quotient
    logic [XLEN-1:0]   opnd_q;    // multiplicand or divisor magnitude
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   result_q;

    // ---------------- request decode ----------------
    logic            accept;
    logic            req_is_div;
    logic            lhs_signed;
    logic            rhs_signed;
    logic            lhs_neg;
    logic            rhs_neg;
    logic [XLEN-1:0] lhs_abs;
    logic [XLEN-1:0] rhs_abs;
    logic            fast_hit;
    logic [XLEN-1:0] fast_res;
    logic            last_iter;

    assign accept     = req_valid_i && (state_q == S_IDLE) && !flush_i;
    assign req_is_div = req_op_i[2];
    // MUL takes the low half, which is sign-agnostic, so it runs unsigned.
    assign lhs_signed = (req_op_i == 3'd1) || (req_op_i == 3'd2) ||
                        (req_op_i == 3'd4) || (req_op_i == 3'd6);
    assign rhs_signed = (req_op_i == 3'd1) || (req_op_i == 3'd4) || (req_op_i == 3'd6);
    assign lhs_neg    = lhs_signed && req_lhs_i[XLEN-1];
    assign rhs_neg    = rhs_signed && req_rhs_i[XLEN-1];
    assign lhs_abs    = lhs_neg ? (~req_lhs_i + 1'b1) : req_lhs_i;
    assign rhs_abs    = rhs_neg ? (~req_rhs_i + 1'b1) : req_rhs_i;
    assign last_iter  = (cnt_q == CNT_W'(XLEN - 1));

`ifdef MDU_FAST_PATH_EN
    logic req_div_zero;
    logic req_ovf;
    assign req_div_zero = (req_rhs_i == '0);
    assign req_ovf      = ((req_op_i == 3'd4) || (req_op_i == 3'd6)) &&
                          (req_lhs_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                          (req_rhs_i == '1);
    always_comb begin
        fast_hit = 1'b0;
        fast_res = '0;
        if (req_is_div) begin
            if (req_div_zero) begin
                fast_hit = 1'b1;
                fast_res = req_op_i[1] ? req_lhs_i : '1;
            end else if (req_ovf) begin
                fast_hit = 1'b1;
                fast_res = req_op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            end
        end else if ((req_lhs_i == '0) || (req_rhs_i == '0)) begin
            fast_hit = 1'b1;
            fast_res = '0;
        end
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    // ---------------- one iteration ----------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_ge;
    logic [XLEN-1:0] iter_hi;
    logic [XLEN-1:0] iter_lo;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (op_q[2]) begin
            iter_hi = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            iter_lo = {lo_q[XLEN-2:0], div_ge};
        end else begin
            iter_hi = mul_sum[XLEN:1];
            iter_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // ---------------- sign fix-up on the final iteration ----------------
    logic [2*XLEN-1:0] prod_mag;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quot_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_mag = {iter_hi, iter_lo};
        prod_s   = (sign_l_q ^ sign_r_q) ? (~prod_mag + 1'b1) : prod_mag;
        // A zero divisor yields an all-ones magnitude quotient, which must
        // stay all-ones regardless of the dividend sign.
        quot_s   = (sign_l_q ^ sign_r_q) && !div_zero_q ? (~iter_lo + 1'b1) : iter_lo;
        rem_s    = sign_l_q ? (~iter_hi + 1'b1) : iter_hi;
        if (op_q[2])
            final_res = op_q[1] ? rem_s : quot_s;
        else
            final_res = (op_q[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = fast_hit ? S_DONE : S_CALC;
            S_CALC: begin
                if (flush_i)        state_d = S_IDLE;
                else if (last_iter) state_d = S_DONE;
            end
            S_DONE: if (flush_i || resp_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready_o  = (state_q == S_IDLE);
        resp_valid_o = (state_q == S_DONE);
        busy_o       = (state_q != S_IDLE);
    end

    assign resp_result_o = result_q;

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q       <= '0;
            sign_l_q   <= 1'b0;
            sign_r_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            opnd_q     <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
        end else if (accept) begin
            op_q       <= req_op_i;
            sign_l_q   <= lhs_neg;
            sign_r_q   <= rhs_neg;
            div_zero_q <= (req_rhs_i == '0);
            hi_q       <= '0;
            lo_q       <= req_is_div ? lhs_abs : rhs_abs;
            opnd_q     <= req_is_div ? rhs_abs : lhs_abs;
            cnt_q      <= '0;
            if (fast_hit)
                result_q <= fast_res;
        end else if ((state_q == S_CALC) && !flush_i) begin
            hi_q <= iter_hi;
            lo_q <= iter_lo;
            if (last_iter) begin
                cnt_q    <= '0;
                result_q <= final_res;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - self-checking bench for mdu_seq
module tb_mdu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_lhs = 32'd0;
    logic [31:0] req_rhs = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_result;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef MDU_FAST_PATH_EN
    localparam int FAST_LAT = 1;
`else
    localparam int FAST_LAT = 33;
`endif
    localparam int NORM_LAT = 33;

    mdu_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .flush_i       (flush),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_lhs_i     (req_lhs),
        .req_rhs_i     (req_rhs),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_result_o (resp_result),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [31:0] exp;
        logic        fast;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents a request for one clock; returns at the negedge of cycle T+1.
    task automatic start_op(input logic [2:0] op, input logic [31:0] l, input logic [31:0] r);
        @(negedge clk);
        req_op = op; req_lhs = l; req_rhs = r; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_lhs = 32'hDEAD_BEEF; req_rhs = 32'h1234_5678;
    endtask

    // Counts accept-edge-inclusive clock edges until resp_valid, bounded.
    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!resp_valid && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        start_op(v.op, v.lhs, v.rhs);
        wait_resp(cyc);
        chk({v.name, " latency"}, cyc, v.fast ? FAST_LAT : NORM_LAT);
        chk({v.name, " result"}, resp_result, v.exp);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk({v.name, " resp_valid drop"}, {31'd0, resp_valid}, 32'd0);
        chk({v.name, " req_ready back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int cyc;
        vecs.push_back('{"MUL 7*-3",       3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{"MULHU max*max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{"MULH -7*2",      3'd1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"MULHSU -1*max",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"MULH min*min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
        vecs.push_back('{"MUL 0*x",        3'd0, 32'h0000_0000, 32'h0000_1234, 32'h0000_0000, 1'b1});
        vecs.push_back('{"DIV -7/2",       3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"REM -7/2",       3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{"DIV 7/-2",       3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{"REM 7/-2",       3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0});
        vecs.push_back('{"DIVU min/3",     3'd5, 32'h8000_0000, 32'h0000_0003, 32'h2AAA_AAAA, 1'b0});
        vecs.push_back('{"REMU min/3",     3'd7, 32'h8000_0000, 32'h0000_0003, 32'h0000_0002, 1'b0});
        vecs.push_back('{"DIVU 5/0",       3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"REM 5/0",        3'd6, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b1});
        vecs.push_back('{"DIV -7/0",       3'd4, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{"DIV ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{"REM ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1});

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_result", resp_result, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Consumer stall: result and handshake held for 5 cycles.
        start_op(3'd5, 32'd100, 32'd7);
        wait_resp(cyc);
        chk("stall latency", cyc, NORM_LAT);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall resp_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall resp_result", resp_result, 32'h0000_000E);
            chk("stall req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("stall release resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("stall release req_ready", {31'd0, req_ready}, 32'd1);

        // flush in IDLE blocks acceptance.
        req_op = 3'd0; req_lhs = 32'd3; req_rhs = 32'd4; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; flush = 1'b0;
        chk("idle flush busy", {31'd0, busy}, 32'd0);

        // flush at T+10 of a DIV.
        start_op(3'd4, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre-flush busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        chk("flush req_ready", {31'd0, req_ready}, 32'd1);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid) cyc++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("flush no resp_valid", cyc, 32'd0);
        run_vec('{"MULH after flush", 3'd1, 32'h4000_0000, 32'h0000_0004, 32'h0000_0001, 1'b0});

        // rst during CALC with a request held.
        start_op(3'd5, 32'd99, 32'd9);
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        req_op = 3'd0; req_lhs = 32'd5; req_rhs = 32'd6; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst calc busy", {31'd0, busy}, 32'd0);
        chk("rst calc req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst calc resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst calc resp_result", resp_result, 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst calc not accepted", {31'd0, busy}, 32'd0);

        // rst while in DONE.
        start_op(3'd0, 32'd6, 32'd7);
        wait_resp(cyc);
        chk("pre-rst done result", resp_result, 32'd42);
        rst = 1'b1;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst done busy", {31'd0, busy}, 32'd0);
        chk("rst done resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst done resp_result", resp_result, 32'd0);
        chk("rst done req_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0; req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst done not accepted", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
